// File: rtl/rom_dl_packer.sv
// rom_dl_packer: packs the data_io ROM download byte stream into 16-bit SDRAM word writes.
// Even/odd byte pairs merge into one word. Lone bytes become half-word writes.
// Each word is routed to the main-CPU region (port1) or the sound-CPU region (port2).
// Writes are issued through a small FIFO using toggle req/ack handshakes.
//
// Ports:
//   clk_sys, reset_n          clock, asynchronous active-low reset
//   ioctl_download/wr/addr/dout
//                             download stream; bytes are taken on the rising edge of ioctl_wr
//   portN_req/ack             toggle handshake; a transfer is done when ack == req
//   portN_a/ds/d/we           word address (region relative), byte enables {hi,lo}, data, write
//   busy                      high from the start of a download until it has drained
//   rom_loaded                sticky; set when a download has fully drained
//   overflow                  sticky; a packed word was dropped because the FIFO was full
module rom_dl_packer #(
  parameter logic [24:0] SND_BASE   = 25'h10000,
  parameter logic [24:0] GFX_BASE   = 25'h12000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic        busy,
  output logic        rom_loaded,
  output logic        overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [23:0] SndWord = SND_BASE[24:1];

  typedef struct packed {
    logic        snd;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } entry_t;

  typedef enum logic [1:0] {PkIdle, PkFlush, PkPush} pk_e;
  typedef enum logic {IsIdle, IsWait} is_e;

  // Word address as seen by the target port (sound region is rebased to zero).
  function automatic entry_t make_entry(input logic snd, input logic [23:0] waddr,
                                        input logic [1:0] ds, input logic [15:0] d);
    entry_t e;
    e.snd = snd;
    e.a   = 23'(snd ? (waddr - SndWord) : waddr);
    e.ds  = ds;
    e.d   = d;
    return e;
  endfunction

  // Edge detection and byte latch
  logic        wr_q, dl_q;
  logic [24:0] lat_addr_q;
  logic [7:0]  lat_data_q;
  logic        ev, ev_rom, ev_snd, lat_snd, dl_rise;

  assign ev      = ioctl_wr & ~wr_q & ioctl_download;
  assign ev_rom  = ev && (ioctl_addr < GFX_BASE);
  assign ev_snd  = ioctl_addr >= SND_BASE;
  assign lat_snd = lat_addr_q >= SND_BASE;
  assign dl_rise = ioctl_download & ~dl_q;

  // Packer
  pk_e         pk_q, pk_d;
  logic        pend_valid_q, pend_valid_d;
  logic [23:0] pend_waddr_q, pend_waddr_d;
  logic        pend_snd_q, pend_snd_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        push;
  entry_t      push_e;

  // FIFO
  entry_t          mem_q [FIFO_DEPTH];
  logic [PtrW:0]   wptr_q, rptr_q;
  logic            empty, full, pop;
  entry_t          head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign head  = mem_q[rptr_q[PtrW-1:0]];

  // Issue
  is_e         is_q, is_d;
  logic        cur_snd_q, cur_snd_d;
  logic        p1_req_q, p1_req_d, p1_we_q, p1_we_d;
  logic [22:0] p1_a_q, p1_a_d;
  logic [1:0]  p1_ds_q, p1_ds_d;
  logic [15:0] p1_d_q, p1_d_d;
  logic        p2_req_q, p2_req_d, p2_we_q, p2_we_d;
  logic [22:0] p2_a_q, p2_a_d;
  logic [1:0]  p2_ds_q, p2_ds_d;
  logic [15:0] p2_d_q, p2_d_d;

  // Status
  logic busy_q, loaded_q, ovf_q, drained;

  always_comb begin
    pk_d         = pk_q;
    pend_valid_d = pend_valid_q;
    pend_waddr_d = pend_waddr_q;
    pend_snd_d   = pend_snd_q;
    pend_data_d  = pend_data_q;
    push         = 1'b0;
    push_e       = '0;
    case (pk_q)
      PkIdle: begin
        if (ev_rom) begin
          if (!ioctl_addr[0]) begin
            if (pend_valid_q) begin
              pk_d = PkFlush;
            end else begin
              pend_valid_d = 1'b1;
              pend_waddr_d = ioctl_addr[24:1];
              pend_snd_d   = ev_snd;
              pend_data_d  = ioctl_dout;
            end
          end else if (pend_valid_q && pend_waddr_q == ioctl_addr[24:1] &&
                       pend_snd_q == ev_snd) begin
            push         = 1'b1;
            push_e       = make_entry(pend_snd_q, pend_waddr_q, 2'b11, {ioctl_dout, pend_data_q});
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            pk_d = PkFlush;
          end else begin
            push   = 1'b1;
            push_e = make_entry(ev_snd, ioctl_addr[24:1], 2'b10, {ioctl_dout, 8'h00});
          end
        end else if (!ioctl_download && pend_valid_q) begin
          // Download ended with a lone even byte left over.
          push         = 1'b1;
          push_e       = make_entry(pend_snd_q, pend_waddr_q, 2'b01, {8'h00, pend_data_q});
          pend_valid_d = 1'b0;
        end
      end
      PkFlush: begin
        push   = 1'b1;
        push_e = make_entry(pend_snd_q, pend_waddr_q, 2'b01, {8'h00, pend_data_q});
        if (!lat_addr_q[0]) begin
          pend_valid_d = 1'b1;
          pend_waddr_d = lat_addr_q[24:1];
          pend_snd_d   = lat_snd;
          pend_data_d  = lat_data_q;
          pk_d         = PkIdle;
        end else begin
          pend_valid_d = 1'b0;
          pk_d         = PkPush;
        end
      end
      PkPush: begin
        push   = 1'b1;
        push_e = make_entry(lat_snd, lat_addr_q[24:1], 2'b10, {lat_data_q, 8'h00});
        pk_d   = PkIdle;
      end
      default: pk_d = PkIdle;
    endcase
  end

  always_comb begin
    is_d      = is_q;
    cur_snd_d = cur_snd_q;
    pop       = 1'b0;
    p1_req_d  = p1_req_q;
    p1_we_d   = p1_we_q;
    p1_a_d    = p1_a_q;
    p1_ds_d   = p1_ds_q;
    p1_d_d    = p1_d_q;
    p2_req_d  = p2_req_q;
    p2_we_d   = p2_we_q;
    p2_a_d    = p2_a_q;
    p2_ds_d   = p2_ds_q;
    p2_d_d    = p2_d_q;
    case (is_q)
      IsIdle: begin
        if (!empty) begin
          cur_snd_d = head.snd;
          is_d      = IsWait;
          if (head.snd) begin
            p2_req_d = ~p2_req_q;
            p2_we_d  = 1'b1;
            p2_a_d   = head.a;
            p2_ds_d  = head.ds;
            p2_d_d   = head.d;
          end else begin
            p1_req_d = ~p1_req_q;
            p1_we_d  = 1'b1;
            p1_a_d   = head.a;
            p1_ds_d  = head.ds;
            p1_d_d   = head.d;
          end
        end
      end
      IsWait: begin
        // The head stays in the FIFO until acknowledged.
        if (cur_snd_q ? (port2_ack == p2_req_q) : (port1_ack == p1_req_q)) begin
          pop     = 1'b1;
          p1_we_d = 1'b0;
          p2_we_d = 1'b0;
          is_d    = IsIdle;
        end
      end
      default: is_d = IsIdle;
    endcase
  end

  assign drained = ~ioctl_download & ~pend_valid_q & empty & (is_q == IsIdle) & (pk_q == PkIdle);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q         <= 1'b0;
      dl_q         <= 1'b0;
      lat_addr_q   <= '0;
      lat_data_q   <= '0;
      pk_q         <= PkIdle;
      pend_valid_q <= 1'b0;
      pend_waddr_q <= '0;
      pend_snd_q   <= 1'b0;
      pend_data_q  <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      is_q         <= IsIdle;
      cur_snd_q    <= 1'b0;
      p1_req_q     <= 1'b0;
      p1_we_q      <= 1'b0;
      p1_a_q       <= '0;
      p1_ds_q      <= '0;
      p1_d_q       <= '0;
      p2_req_q     <= 1'b0;
      p2_we_q      <= 1'b0;
      p2_a_q       <= '0;
      p2_ds_q      <= '0;
      p2_d_q       <= '0;
      busy_q       <= 1'b0;
      loaded_q     <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      wr_q <= ioctl_wr;
      dl_q <= ioctl_download;
      if (ev && pk_q == PkIdle) begin
        lat_addr_q <= ioctl_addr;
        lat_data_q <= ioctl_dout;
      end
      pk_q         <= pk_d;
      pend_valid_q <= pend_valid_d;
      pend_waddr_q <= pend_waddr_d;
      pend_snd_q   <= pend_snd_d;
      pend_data_q  <= pend_data_d;
      if (push && !full) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      is_q      <= is_d;
      cur_snd_q <= cur_snd_d;
      p1_req_q  <= p1_req_d;
      p1_we_q   <= p1_we_d;
      p1_a_q    <= p1_a_d;
      p1_ds_q   <= p1_ds_d;
      p1_d_q    <= p1_d_d;
      p2_req_q  <= p2_req_d;
      p2_we_q   <= p2_we_d;
      p2_a_q    <= p2_a_d;
      p2_ds_q   <= p2_ds_d;
      p2_d_q    <= p2_d_d;
      if (dl_rise) begin
        busy_q   <= 1'b1;
        loaded_q <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        if (busy_q && drained) begin
          busy_q   <= 1'b0;
          loaded_q <= 1'b1;
        end
        if (push && full) ovf_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset; only the pointers define occupancy.
  always_ff @(posedge clk_sys) begin
    if (push && !full) mem_q[wptr_q[PtrW-1:0]] <= push_e;
  end

  assign port1_req  = p1_req_q;
  assign port1_we   = p1_we_q;
  assign port1_a    = p1_a_q;
  assign port1_ds   = p1_ds_q;
  assign port1_d    = p1_d_q;
  assign port2_req  = p2_req_q;
  assign port2_we   = p2_we_q;
  assign port2_a    = p2_a_q;
  assign port2_ds   = p2_ds_q;
  assign port2_d    = p2_d_q;
  assign busy       = busy_q;
  assign rom_loaded = loaded_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_rom_dl_packer.sv
// Bench for rom_dl_packer: directed cases plus random download streams, checked against
// a byte-list reference model of the expected SDRAM word writes.
module tb_rom_dl_packer;

  localparam logic [24:0] SndBase = 25'h10000;
  localparam logic [24:0] GfxBase = 25'h12000;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req, port1_ack, port1_we;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req, port2_ack, port2_we;
  logic [22:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        busy, rom_loaded, overflow;

  rom_dl_packer #(
    .SND_BASE   (SndBase),
    .GFX_BASE   (GfxBase),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .port1_req      (port1_req),
    .port1_ack      (port1_ack),
    .port1_a        (port1_a),
    .port1_ds       (port1_ds),
    .port1_d        (port1_d),
    .port1_we       (port1_we),
    .port2_req      (port2_req),
    .port2_ack      (port2_ack),
    .port2_a        (port2_a),
    .port2_ds       (port2_ds),
    .port2_d        (port2_d),
    .port2_we       (port2_we),
    .busy           (busy),
    .rom_loaded     (rom_loaded),
    .overflow       (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } byte_t;

  byte_t       bytes_q[$];
  logic [41:0] obs_q[$];  // {port, a, ds, d} as seen on the bus
  logic [41:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int stab_err = 0, we_err = 0, multi_err = 0;
  bit hold = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // SDRAM stand-in: records each request, acks after a random latency unless held.
  logic        prev1, prev2;
  int          cnt1, cnt2, lat1, lat2;
  logic [40:0] last1, last2;

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      port1_ack = 1'b0;
      port2_ack = 1'b0;
      prev1 = 1'b0;
      prev2 = 1'b0;
      cnt1 = 0;
      cnt2 = 0;
    end else begin
      if (port1_req != prev1) begin
        prev1 = port1_req;
        last1 = {port1_a, port1_ds, port1_d};
        obs_q.push_back({1'b0, last1});
        if (!port1_we) we_err++;
        if (port2_req != port2_ack) multi_err++;
        lat1 = int'($urandom_range(0, 4));
        cnt1 = 0;
      end else if (port1_req != port1_ack && {port1_a, port1_ds, port1_d} != last1) begin
        stab_err++;
      end
      if (port2_req != prev2) begin
        prev2 = port2_req;
        last2 = {port2_a, port2_ds, port2_d};
        obs_q.push_back({1'b1, last2});
        if (!port2_we) we_err++;
        if (port1_req != port1_ack) multi_err++;
        lat2 = int'($urandom_range(0, 4));
        cnt2 = 0;
      end else if (port2_req != port2_ack && {port2_a, port2_ds, port2_d} != last2) begin
        stab_err++;
      end
      if (port1_req != port1_ack && !hold) begin
        if (cnt1 >= lat1) port1_ack = port1_req;
        else cnt1++;
      end
      if (port2_req != port2_ack && !hold) begin
        if (cnt2 >= lat2) port2_ack = port2_req;
        else cnt2++;
      end
    end
  end

  function automatic logic [41:0] ent(input bit snd, input logic [23:0] word,
                                      input logic [1:0] ds, input logic [15:0] d);
    logic [22:0] pa;
    pa = 23'(snd ? word - 24'(SndBase >> 1) : word);
    return {snd, pa, ds, d};
  endfunction

  // Reference: walk the byte list in order, keeping at most one unmatched even byte.
  task automatic build_expected();
    bit pv = 0;
    bit ps = 0;
    logic [23:0] pw = '0;
    logic [7:0] pd = '0;
    exp_q.delete();
    foreach (bytes_q[i]) begin
      logic [24:0] a = bytes_q[i].addr;
      logic [7:0]  d = bytes_q[i].data;
      bit snd = (a >= SndBase);
      logic [23:0] w = a[24:1];
      if (a < GfxBase) begin
        if (!a[0]) begin
          if (pv) exp_q.push_back(ent(ps, pw, 2'b01, {8'h00, pd}));
          pv = 1; ps = snd; pw = w; pd = d;
        end else if (pv && pw == w && ps == snd) begin
          exp_q.push_back(ent(ps, pw, 2'b11, {d, pd}));
          pv = 0;
        end else begin
          if (pv) exp_q.push_back(ent(ps, pw, 2'b01, {8'h00, pd}));
          pv = 0;
          exp_q.push_back(ent(snd, w, 2'b10, {d, 8'h00}));
        end
      end
    end
    if (pv) exp_q.push_back(ent(ps, pw, 2'b01, {8'h00, pd}));
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int gap);
    @(posedge clk_sys); #1;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    bytes_q.push_back('{addr: a, data: d});
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    repeat (gap) @(posedge clk_sys);
  endtask

  task automatic start_dl(input string tag);
    @(posedge clk_sys); #1;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    check_eq({tag, "_busy_set"}, 64'(busy), 64'd1);
    check_eq({tag, "_loaded_clr"}, 64'(rom_loaded), 64'd0);
    check_eq({tag, "_ovf_clr"}, 64'(overflow), 64'd0);
  endtask

  task automatic end_dl();
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
  endtask

  task automatic wait_loaded(input string tag);
    int i = 0;
    while (!rom_loaded && i < 400) begin
      @(posedge clk_sys); #1;
      i++;
    end
    check_eq({tag, "_loaded"}, 64'(rom_loaded), 64'd1);
    check_eq({tag, "_busy_clr"}, 64'(busy), 64'd0);
  endtask

  // Compare the first n observed writes (all if n < 0) against the model.
  task automatic compare_run(input string tag, input int n);
    int cnt;
    build_expected();
    cnt = (n < 0) ? exp_q.size() : n;
    check_eq({tag, "_nwrites"}, 64'(obs_q.size()), 64'(cnt));
    for (int i = 0; i < cnt && i < obs_q.size(); i++)
      check_eq($sformatf("%s_wr%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    check_eq({tag, "_stable"}, 64'(stab_err), 64'd0);
    check_eq({tag, "_we"}, 64'(we_err), 64'd0);
    check_eq({tag, "_single"}, 64'(multi_err), 64'd0);
    bytes_q.delete();
    obs_q.delete();
    stab_err = 0; we_err = 0; multi_err = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_eq("rst_p1", 64'({port1_req, port1_a, port1_ds, port1_d, port1_we}), 64'd0);
    check_eq("rst_p2", 64'({port2_req, port2_a, port2_ds, port2_d, port2_we}), 64'd0);
    check_eq("rst_status", 64'({busy, rom_loaded, overflow}), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);

    // Pair merge
    start_dl("merge");
    send_byte(25'h0, 8'hAA, 8);
    send_byte(25'h1, 8'h55, 8);
    end_dl();
    wait_loaded("merge");
    check_eq("merge_value", 64'(obs_q.size() > 0 ? obs_q[0] : '0), 64'({1'b0, 23'd0, 2'b11, 16'h55AA}));
    compare_run("merge", -1);

    // Region split, last sound word, GFX drop
    start_dl("split");
    send_byte(25'h10002, 8'h12, 8);
    send_byte(25'h10003, 8'h34, 8);
    send_byte(25'h11FFF, 8'h9C, 8);
    send_byte(25'h12000, 8'h77, 8);
    send_byte(25'h12001, 8'h88, 8);
    end_dl();
    wait_loaded("split");
    compare_run("split", -1);

    // Partial words with completion held off by ack
    start_dl("partial");
    send_byte(25'h4, 8'hC3, 8);
    send_byte(25'h7, 8'h5A, 8);
    send_byte(25'h8, 8'h11, 8);
    hold = 1'b1;
    end_dl();
    repeat (20) @(posedge clk_sys);
    #1;
    check_eq("partial_loaded_held", 64'(rom_loaded), 64'd0);
    check_eq("partial_busy_held", 64'(busy), 64'd1);
    hold = 1'b0;
    wait_loaded("partial");
    compare_run("partial", -1);

    // Back-pressure within the byte-rate budget
    start_dl("bp");
    hold = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(25'h40 + 25'(i), 8'(8'h10 * i + 1), 8);
    repeat (120) @(posedge clk_sys);
    #1;
    check_eq("bp_one_outstanding", 64'(obs_q.size()), 64'd1);
    check_eq("bp_overflow", 64'(overflow), 64'd0);
    hold = 1'b0;
    end_dl();
    wait_loaded("bp");
    compare_run("bp", -1);

    // Bytes faster than the FIFO can absorb
    start_dl("ovf");
    hold = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(25'h100 + 25'(i), 8'($urandom), 0);
    repeat (4) @(posedge clk_sys);
    #1;
    check_eq("ovf_set", 64'(overflow), 64'd1);
    hold = 1'b0;
    end_dl();
    wait_loaded("ovf");
    check_eq("ovf_sticky", 64'(overflow), 64'd1);
    compare_run("ovf", 4);

    // Random streams across all three regions
    for (int r = 0; r < 4; r++) begin
      start_dl("rnd");
      for (int k = 0; k < 10; k++) begin
        int unsigned sel = $urandom_range(0, 9);
        int unsigned len = $urandom_range(1, 5);
        logic [24:0] base;
        if (sel < 5) base = 25'($urandom_range(0, 32'hFFF0));
        else if (sel < 9) base = SndBase + 25'($urandom_range(0, 32'h1FF0));
        else base = GfxBase + 25'($urandom_range(0, 255));
        for (int j = 0; j < int'(len); j++) begin
          logic [24:0] a = base + 25'(j);
          if ($urandom_range(0, 5) == 0) a = a + 25'd1;
          send_byte(a, 8'($urandom), int'($urandom_range(6, 10)));
        end
      end
      end_dl();
      wait_loaded($sformatf("rnd%0d", r));
      check_eq($sformatf("rnd%0d_ovf", r), 64'(overflow), 64'd0);
      compare_run($sformatf("rnd%0d", r), -1);
    end

    // Asynchronous reset while a request waits for ack
    start_dl("arst");
    hold = 1'b1;
    send_byte(25'h20, 8'h01, 8);
    send_byte(25'h21, 8'h02, 2);
    begin
      int i = 0;
      while (!port1_we && i < 20) begin
        @(posedge clk_sys); #1;
        i++;
      end
      check_eq("arst_we_before", 64'(port1_we), 64'd1);
    end
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("arst_p1", 64'({port1_req, port1_a, port1_ds, port1_d, port1_we}), 64'd0);
    check_eq("arst_p2_status",
             64'({port2_req, port2_a, port2_ds, port2_d, port2_we, busy, rom_loaded, overflow}),
             64'd0);
    ioctl_download = 1'b0;
    hold = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    bytes_q.delete();
    obs_q.delete();
    stab_err = 0; we_err = 0; multi_err = 0;
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    start_dl("post");
    send_byte(25'h30, 8'hDE, 8);
    send_byte(25'h31, 8'hAD, 8);
    end_dl();
    wait_loaded("post");
    compare_run("post", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
